// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures high/low/period of a slow asynchronous square wave in clk cycles.
// Reports loss of activity through timeout and captures the idle level at that point.
module clock_period_meter #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clk_in,
  output logic [COUNT_WIDTH-1:0] high_cycles,
  output logic [COUNT_WIDTH-1:0] low_cycles,
  output logic [COUNT_WIDTH:0]   period_cycles,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   timeout,
  output logic                   idle_level
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_TRIP = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     prev;
  logic [COUNT_WIDTH-1:0]   cnt;
  logic [COUNT_WIDTH-1:0]   high_tmp;
  logic                     seen_lock;

  logic                     sync_lvl;
  logic                     rise;
  logic                     fall;
  logic                     qual_edge;
  logic                     trip;
  logic [COUNT_WIDTH-1:0]   cnt_plus1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sync_lvl  = sync_q[SYNC_STAGES-1];
    rise      = sync_lvl & ~prev;
    fall      = ~sync_lvl & prev;
    cnt_plus1 = cnt + 1'b1;
    qual_edge = ((state == ARM) && rise) || ((state == HIGH) && fall) ||
                ((state == LOW) && rise);
    // ARM only watches for a timeout once a lock has been achieved since enable,
    // otherwise waiting for a first edge would raise timeout spuriously.
    trip      = (cnt == CNT_TRIP) && !qual_edge &&
                ((state == HIGH) || (state == LOW) || ((state == ARM) && seen_lock));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      high_tmp      <= '0;
      seen_lock     <= 1'b0;
      high_cycles   <= '0;
      low_cycles    <= '0;
      period_cycles <= '0;
      period_valid  <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
      idle_level    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        cnt       <= '0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
        seen_lock <= 1'b0;
      end else begin
        if (qual_edge) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt_plus1;
        end

        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              high_tmp <= cnt_plus1;
              state    <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              high_cycles   <= high_tmp;
              low_cycles    <= cnt_plus1;
              period_cycles <= {1'b0, high_tmp} + {1'b0, cnt_plus1};
              period_valid  <= 1'b1;
              locked        <= 1'b1;
              timeout       <= 1'b0;
              seen_lock     <= 1'b1;
              state         <= HIGH;
            end
          end
          default: state <= IDLE;
        endcase

        // cnt lands on CNT_MAX here and then saturates, so the trip fires once.
        if (trip) begin
          timeout    <= 1'b1;
          locked     <= 1'b0;
          idle_level <= sync_lvl;
          state      <= ARM;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - scoreboard bench for clock_period_meter.
// Stimulus drives clk_in phases and queues expected reports; a monitor checks each period_valid.
module tb_clock_period_meter;

  localparam int CW = 4;
  localparam int SS = 2;

  typedef struct {
    int h;
    int l;
    bit first;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clk_in = 1'b0;
  logic [CW-1:0] high_cycles;
  logic [CW-1:0] low_cycles;
  logic [CW:0]   period_cycles;
  logic          period_valid;
  logic          locked;
  logic          timeout;
  logic          idle_level;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pulse = 0;

  clock_period_meter #(.COUNT_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clk_in(clk_in),
    .high_cycles(high_cycles), .low_cycles(low_cycles), .period_cycles(period_cycles),
    .period_valid(period_valid), .locked(locked), .timeout(timeout), .idle_level(idle_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({high_cycles, low_cycles, period_cycles, period_valid, locked, timeout, idle_level});
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (period_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("high_cycles", int'(high_cycles), e.h);
        chk("low_cycles", int'(low_cycles), e.l);
        chk("period_cycles", int'(period_cycles), e.h + e.l);
        chk("locked_on_pulse", int'(locked), 1);
        chk("timeout_on_pulse", int'(timeout), 0);
        if (!e.first) chk("pulse_spacing", cyc - last_pulse, e.h + e.l);
      end
      last_pulse = cyc;
    end
  end

  task automatic drive(input logic lvl, input int n);
    clk_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int h, input int l, input bit first);
    exp_t e;
    e.h = h;
    e.l = l;
    e.first = first;
    q.push_back(e);
  endtask

  task automatic restart();
    clk_in = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic close_and_drain(input string name);
    clk_in = 1'b1;
    repeat (SS + 3) @(negedge clk);
    chk(name, q.size(), 0);
  endtask

  task automatic train(input int n, input int h, input int l, input bit rnd);
    int hh;
    int ll;
    restart();
    drive(1'b0, SS + 3);
    for (int i = 0; i < n; i++) begin
      hh = rnd ? int'($urandom_range(12, 2)) : h;
      ll = rnd ? int'($urandom_range(12, 2)) : l;
      drive(1'b1, hh);
      drive(1'b0, ll);
      push(hh, ll, i == 0);
    end
    close_and_drain("train_drained");
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      clk_in = ~clk_in;
      @(negedge clk);
      chk("reset_outputs_zero", all_outs(), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(i[0], 3);
    chk("idle_no_lock", int'(locked), 0);
    chk("idle_outputs_zero", all_outs(), 0);

    train(6, 5, 5, 1'b0);
    chk("sym_locked", int'(locked), 1);
    train(4, 3, 7, 1'b0);
    train(25, 0, 0, 1'b1);

    // Timeout: lock on 4/4, then hold clk_in high.
    train(3, 4, 4, 1'b0);
    n = SS + 3;
    while (!timeout && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_delay", n, SS + (1 << CW));
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_idle_level", int'(idle_level), 1);
    chk("timeout_high_hold", int'(high_cycles), 4);
    chk("timeout_low_hold", int'(low_cycles), 4);
    chk("timeout_period_hold", int'(period_cycles), 8);
    drive(1'b0, 4);
    drive(1'b1, 4);
    chk("timeout_held", int'(timeout), 1);
    drive(1'b0, 4);
    push(4, 4, 1'b1);
    close_and_drain("resume_drained");
    chk("timeout_cleared", int'(timeout), 0);

    // Enable drop on the same cycle the LOW-ending rise is detected.
    restart();
    drive(1'b0, SS + 3);
    drive(1'b1, 5);
    drive(1'b0, 5);
    push(5, 5, 1'b1);
    drive(1'b1, 5);
    drive(1'b0, 5);
    clk_in = 1'b1;
    repeat (SS) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_locked", int'(locked), 0);
    chk("drop_no_pulse", int'(period_valid), 0);
    drive(1'b1, 2);
    enable = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 6);
    drive(1'b0, 6);
    push(6, 6, 1'b1);
    close_and_drain("reenable_drained");

    // Asynchronous reset between clk edges while locked.
    restart();
    drive(1'b0, SS + 3);
    drive(1'b1, 5);
    drive(1'b0, 5);
    push(5, 5, 1'b1);
    close_and_drain("prereset_drained");
    chk("prereset_locked", int'(locked), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_zero", all_outs(), 0);
    clk_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, SS + 3);
    drive(1'b1, 7);
    drive(1'b0, 3);
    push(7, 3, 1'b1);
    close_and_drain("relock_drained");
    chk("relock_locked", int'(locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
